// File: rtl/hdmi_pll_cfg_pkg.sv
// Shared definitions for the HDMI pixel-clock PLL reconfiguration sequencer.
// Contents: reconfig-core register addresses, fixed MODE/START write data,
// the 18-bit counter-word type and the sequencer state enum.
package hdmi_pll_cfg_pkg;

    // Reconfiguration core register map
    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    // MODE=0 selects waitrequest mode; writing 1 to START launches the retune
    localparam logic [31:0] MODE_DATA  = 32'd0;
    localparam logic [31:0] START_DATA = 32'd1;

    // Counter word: [17] odd, [16] bypass, [15:8] high count, [7:0] low count
    typedef logic [17:0] cnt_word_t;

    typedef enum logic [3:0] {
        StIdle,
        StWrMode,
        StWrN,
        StWrM,
        StWrC0,
        StWrK,
        StWrStart,
        StWaitBusy,
        StWaitLock
    } state_t;

    // Zero-extend a counter word onto the 32-bit mgmt bus. For C0 the upper
    // bits [22:18] are the counter select, which is 0 here.
    function automatic logic [31:0] cnt_word_data(input cnt_word_t w);
        return {14'd0, w};
    endfunction

endpackage

// File: rtl/hdmi_pll_lock_mon.sv
// PLL lock monitor: synchronises the asynchronous pll_locked into the mgmt
// clock domain and measures how long lock has been continuously held.
// Optional feature macro: HDMI_PLL_LOCK_TIMEOUT_EN adds a 20-bit timeout counter.
// Ports:
//   clk        in   mgmt clock
//   rst_n      in   synchronous reset, active low
//   arm        in   high while the sequencer waits for lock; low clears counters
//   pll_locked in   raw PLL lock (asynchronous)
//   stable     out  lock held LOCK_STABLE consecutive synced cycles (while armed)
//   timeout    out  armed for LOCK_TIMEOUT cycles without stability (macro only)
module hdmi_pll_lock_mon #(
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic pll_locked,
    output logic stable,
    output logic timeout
);

    localparam int unsigned SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);

    logic          locked_meta_q;
    logic          locked_sync_q;
    logic [SW-1:0] stable_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_meta_q <= 1'b0;
            locked_sync_q <= 1'b0;
            stable_cnt_q  <= '0;
        end else begin
            locked_meta_q <= pll_locked;
            locked_sync_q <= locked_meta_q;
            // Any loss of lock restarts the stability window
            if (arm && locked_sync_q) begin
                stable_cnt_q <= stable_cnt_q + SW'(1);
            end else begin
                stable_cnt_q <= '0;
            end
        end
    end

    assign stable = arm && locked_sync_q && (stable_cnt_q == STABLE_LAST);

`ifdef HDMI_PLL_LOCK_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);

    logic [19:0] timeout_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_cnt_q <= '0;
        end else if (arm) begin
            timeout_cnt_q <= timeout_cnt_q + 20'd1;
        end else begin
            timeout_cnt_q <= '0;
        end
    end

    assign timeout = arm && (timeout_cnt_q == TIMEOUT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(LOCK_TIMEOUT);
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/hdmi_pll_reconfig_seq.sv
// HDMI pixel-clock PLL retune sequencer. Takes one N/M/C0/K set per handshake,
// writes MODE, N, M, C0, [K], START to the reconfig core's Avalon-MM mgmt port,
// waits for the core to finish and for stable lock, then pulses done (or error).
// Optional feature macro: HDMI_PLL_LOCK_TIMEOUT_EN enables the lock timeout.
// Ports:
//   clk, rst_n            mgmt clock, synchronous active-low reset
//   cfg_valid/cfg_ready   request handshake (ready only in IDLE)
//   cfg_n/m/c0            18-bit counter words; cfg_k fractional K; cfg_frac writes K
//   mgmt_address/write/writedata/waitrequest   reconfig core mgmt port
//   pll_locked            raw PLL lock (asynchronous)
//   busy                  request in progress
//   done / error          1-cycle completion / lock-timeout pulses
module hdmi_pll_reconfig_seq
    import hdmi_pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    input  logic        cfg_frac,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state_q, state_d;
    cnt_word_t   n_q, m_q, c0_q;
    logic [31:0] k_q;
    logic        frac_q;
    logic        lock_stable, lock_timeout;

    hdmi_pll_lock_mon #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (state_q == StWaitLock),
        .pll_locked (pll_locked),
        .stable     (lock_stable),
        .timeout    (lock_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            m_q     <= '0;
            c0_q    <= '0;
            k_q     <= '0;
            frac_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cfg_valid) begin
                n_q    <= cfg_n;
                m_q    <= cfg_m;
                c0_q   <= cfg_c0;
                k_q    <= cfg_k;
                frac_q <= cfg_frac;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        done           = 1'b0;
        error          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) state_d = StWrMode;
            end
            StWrMode: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_MODE;
                mgmt_writedata = MODE_DATA;
                if (!mgmt_waitrequest) state_d = StWrN;
            end
            StWrN: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_N;
                mgmt_writedata = cnt_word_data(n_q);
                if (!mgmt_waitrequest) state_d = StWrM;
            end
            StWrM: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_M;
                mgmt_writedata = cnt_word_data(m_q);
                if (!mgmt_waitrequest) state_d = StWrC0;
            end
            StWrC0: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_C;
                mgmt_writedata = cnt_word_data(c0_q);
                if (!mgmt_waitrequest) state_d = frac_q ? StWrK : StWrStart;
            end
            StWrK: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_K;
                mgmt_writedata = k_q;
                if (!mgmt_waitrequest) state_d = StWrStart;
            end
            StWrStart: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_START;
                mgmt_writedata = START_DATA;
                if (!mgmt_waitrequest) state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // Core holds waitrequest high while it reprograms the PLL
                if (!mgmt_waitrequest) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Pulses are suppressed on the reset edge so an aborted retune
                // never reports completion.
                if (lock_stable) begin
                    done    = rst_n;
                    state_d = StIdle;
                end else if (lock_timeout) begin
                    error   = rst_n;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

endmodule
